// File: rtl/custom_waveform_handler.sv
// Waveform upload and playback engine: command payload bytes fill a sample RAM,
// then a 32-bit phase accumulator (12.20 fixed point) steps through it onto the DAC.
module custom_waveform_handler #(
  parameter int          MAX_SAMPLES = 4096,
  parameter int          DAC_WIDTH   = 14,
  parameter logic [7:0]  CMD_UPLOAD  = 8'hFC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           cmd_type,
  input  logic [15:0]          cmd_length,
  input  logic [7:0]           cmd_data,
  input  logic [15:0]          cmd_data_index,
  input  logic                 cmd_start,
  input  logic                 cmd_data_valid,
  input  logic                 cmd_done,
  output logic                 cmd_ready,
  output logic [DAC_WIDTH-1:0] dac_data,
  output logic                 playing
);

  localparam int          ADDR_W = (MAX_SAMPLES > 1) ? $clog2(MAX_SAMPLES) : 1;
  localparam logic [16:0] MAX_K  = 17'(MAX_SAMPLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECEIVE,
    S_PLAY
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] rate_q, rate_d;
  logic [15:0] count_q, count_d;
  logic        loop_q, loop_d;
  logic [7:0]  lo_q, lo_d;
  logic        playing_q, playing_d;
  logic [DAC_WIDTH-1:0] dac_q;

  logic                 dac_load, dac_clr;
  logic                 ram_we;
  logic [ADDR_W-1:0]    ram_waddr;
  logic [DAC_WIDTH-1:0] ram_wdata;
  logic [DAC_WIDTH-1:0] mem [MAX_SAMPLES];

  logic        upload_start;
  logic [15:0] sample_off;
  logic [16:0] sample_k;
  logic        sample_in_range;
  logic        count_ok;
  logic [32:0] span, span_m1, play_next, play_wrap;
  logic [12:0] next_idx;
  logic        unused_bits;

  assign upload_start    = cmd_start && (cmd_type == CMD_UPLOAD);
  assign sample_off      = cmd_data_index - 16'd7;
  assign sample_k        = {2'b00, sample_off[15:1]};
  assign sample_in_range = (cmd_data_index >= 16'd7) && (sample_k < MAX_K);
  assign count_ok        = (count_q != 16'd0) && ({1'b0, count_q} <= MAX_K);

  // Sample index is acc[31:20], so a valid count never exceeds 4096 and fits 13 bits.
  assign span      = {count_q[12:0], 20'h00000};
  assign span_m1   = span - 33'd1;
  assign play_next = {1'b0, acc_q} + {1'b0, rate_q};
  assign play_wrap = play_next - span;
  assign next_idx  = play_next[32:20];

  assign ram_waddr = sample_k[ADDR_W-1:0];
  assign ram_wdata = DAC_WIDTH'({cmd_data[5:0], lo_q});

  // RAM writes never stall, so readiness only depends on being out of reset.
  assign cmd_ready = ~rst;
  assign dac_data  = dac_q;
  assign playing   = playing_q;

  assign unused_bits = ^{cmd_length, acc_q, span_m1[32]};

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    state_d   = state_q;
    acc_d     = acc_q;
    rate_d    = rate_q;
    count_d   = count_q;
    loop_d    = loop_q;
    lo_d      = lo_q;
    playing_d = playing_q;
    dac_load  = 1'b0;
    dac_clr   = 1'b0;
    ram_we    = 1'b0;

    if (upload_start) begin
      state_d   = S_RECEIVE;
      playing_d = 1'b0;
      dac_clr   = 1'b1;
      count_d   = 16'd0;
      rate_d    = 32'd0;
      loop_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          playing_d = 1'b0;
          dac_clr   = 1'b1;
        end

        S_RECEIVE: begin
          dac_clr = 1'b1;
          if (cmd_data_valid) begin
            unique case (cmd_data_index)
              16'd0: loop_d         = cmd_data[2];
              16'd1: count_d[15:8]  = cmd_data;
              16'd2: count_d[7:0]   = cmd_data;
              16'd3: rate_d[31:24]  = cmd_data;
              16'd4: rate_d[23:16]  = cmd_data;
              16'd5: rate_d[15:8]   = cmd_data;
              16'd6: rate_d[7:0]    = cmd_data;
              default: begin
                if (sample_in_range) begin
                  if (!sample_off[0]) lo_d   = cmd_data;
                  else                ram_we = 1'b1;
                end
              end
            endcase
          end
          if (cmd_done) begin
            if (count_ok && (rate_q != 32'd0)) begin
              state_d   = S_PLAY;
              acc_d     = 32'd0;
              playing_d = 1'b1;
              // A step of a whole waveform or more would skip past the wrap point.
              if ({1'b0, rate_q} >= span) rate_d = span_m1[31:0];
            end else begin
              state_d   = S_IDLE;
              playing_d = 1'b0;
            end
          end
        end

        S_PLAY: begin
          dac_load = 1'b1;
          if ({3'b000, next_idx} < count_q) begin
            acc_d = play_next[31:0];
          end else if (loop_q) begin
            acc_d = play_wrap[31:0];
          end else begin
            // playing stays up for the final sample, then IDLE clears both outputs.
            state_d = S_IDLE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= 32'd0;
      rate_q    <= 32'd0;
      count_q   <= 16'd0;
      loop_q    <= 1'b0;
      lo_q      <= 8'd0;
      playing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      rate_q    <= rate_d;
      count_q   <= count_d;
      loop_q    <= loop_d;
      lo_q      <= lo_d;
      playing_q <= playing_d;
    end
  end

  // NOTE: the sample array has no reset so it maps onto block RAM; only the write is gated.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) mem[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || dac_clr) dac_q <= '0;
    else if (dac_load)  dac_q <= mem[acc_q[20 +: ADDR_W]];
  end

endmodule

// File: tb/tb_custom_waveform_handler.sv
// Randomised scoreboard bench for custom_waveform_handler: uploads waveforms and
// compares the DAC stream against an arithmetic phase-accumulator model.
module tb_custom_waveform_handler;

  localparam int MAXS = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cmd_type;
  logic [15:0] cmd_length;
  logic [7:0]  cmd_data;
  logic [15:0] cmd_data_index;
  logic        cmd_start, cmd_data_valid, cmd_done;
  logic        cmd_ready;
  logic [13:0] dac_data;
  logic        playing;

  custom_waveform_handler dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_type       (cmd_type),
    .cmd_length     (cmd_length),
    .cmd_data       (cmd_data),
    .cmd_data_index (cmd_data_index),
    .cmd_start      (cmd_start),
    .cmd_data_valid (cmd_data_valid),
    .cmd_done       (cmd_done),
    .cmd_ready      (cmd_ready),
    .dac_data       (dac_data),
    .playing        (playing)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [13:0] exp_q[$];
  logic [13:0] up_samples[$];
  int          model_ram[int];
  logic [7:0]  m_ctrl;
  logic [15:0] m_cnt;
  logic [31:0] m_rate;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: the DAC stream is valid once playing has been high for a full cycle.
  logic        prev_play = 1'b0;
  logic [13:0] mon_exp;
  always @(negedge clk) begin
    if (playing && prev_play && exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      check("dac_stream", 32'(dac_data), 32'(mon_exp));
    end
    prev_play = playing;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise_start();
    logic [7:0] t;
    t = 8'($urandom_range(0, 255));
    if (t == 8'hFC) t = 8'h10;
    cmd_type  = t;
    cmd_start = 1'b1;
  endtask

  task automatic send_byte(input logic [15:0] idx, input logic [7:0] d);
    cmd_data_valid = 1'b1;
    cmd_data_index = idx;
    cmd_data       = d;
    tick();
    cmd_data_valid = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      if ($urandom_range(0, 3) == 0) noise_start();
      tick();
      cmd_start = 1'b0;
    end
  endtask

  task automatic start_upload();
    cmd_type   = 8'hFC;
    cmd_length = 16'($urandom);
    cmd_start  = 1'b1;
    tick();
    cmd_start = 1'b0;
    check("upload_playing", 32'(playing), 32'd0);
    check("upload_dac", 32'(dac_data), 32'd0);
  endtask

  task automatic send_payload(input logic [7:0] ctrl, input logic [15:0] cnt,
                              input logic [31:0] rate, input int nsamp);
    logic [13:0] s;
    logic [1:0]  top;
    send_byte(16'd0, ctrl);
    send_byte(16'd1, cnt[15:8]);
    send_byte(16'd2, cnt[7:0]);
    send_byte(16'd3, rate[31:24]);
    send_byte(16'd4, rate[23:16]);
    send_byte(16'd5, rate[15:8]);
    send_byte(16'd6, rate[7:0]);
    for (int k = 0; k < nsamp; k++) begin
      s   = up_samples[k];
      top = (s == 14'h3FFF) ? 2'b11 : 2'($urandom_range(0, 3));
      send_byte(16'(7 + 2 * k), s[7:0]);
      send_byte(16'(8 + 2 * k), {top, s[13:8]});
      if (k < MAXS) model_ram[k] = int'(s);
    end
    m_ctrl = ctrl;
    m_cnt  = cnt;
    m_rate = rate;
  endtask

  // Reference: sample j is RAM[floor(phase_j / 2^20)], phase advancing by the clamped step.
  task automatic finish_cmd(output bit plays, output bit lp);
    longint span, step, acc;
    int     n;
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    lp    = m_ctrl[2];
    plays = (m_cnt >= 1) && (int'(m_cnt) <= MAXS) && (m_rate != 0);
    if (plays) begin
      span = longint'(m_cnt) * 1048576;
      step = (longint'(m_rate) >= span) ? span - 1 : longint'(m_rate);
      acc  = 0;
      n    = 0;
      while (1) begin
        exp_q.push_back(14'(model_ram[int'(acc / 1048576)]));
        n++;
        acc += step;
        if (acc >= span) begin
          if (lp) acc -= span;
          else    break;
        end
        if (lp && n >= 24) break;
      end
    end
  endtask

  task automatic drain(input bit noisy);
    int b = 0;
    while (exp_q.size() > 0) begin
      if (noisy && $urandom_range(0, 3) == 0) noise_start();
      tick();
      cmd_start = 1'b0;
      b++;
      if (b > 3000) begin
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
      end
    end
  endtask

  task automatic quiet(input int n, input string nm);
    repeat (n) begin
      tick();
      check({nm, "_playing"}, 32'(playing), 32'd0);
      check({nm, "_dac"}, 32'(dac_data), 32'd0);
    end
  endtask

  task automatic run_upload(input logic [7:0] ctrl, input logic [15:0] cnt,
                            input logic [31:0] rate, input int nsamp);
    bit p, l;
    start_upload();
    send_payload(ctrl, cnt, rate, nsamp);
    finish_cmd(p, l);
    if (p) begin
      drain(1'b1);
      if (!l) begin
        check("end_playing", 32'(playing), 32'd0);
        check("end_dac", 32'(dac_data), 32'd0);
        quiet(3, "no_restart");
      end
    end else begin
      quiet(5, "no_play");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0]  rc;
    logic [15:0] rn;
    logic [31:0] rr;
    bit p, l;

    rst = 1'b1;
    cmd_type = 8'h00; cmd_length = 16'h0; cmd_data = 8'h00; cmd_data_index = 16'h0;
    cmd_start = 1'b0; cmd_data_valid = 1'b0; cmd_done = 1'b0;
    repeat (3) tick();
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_playing", 32'(playing), 32'd0);
    check("rst_dac", 32'(dac_data), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(cmd_ready), 32'd1);
    quiet(2, "idle");

    // Looping 4-sample waveform, one sample per clock; aborted by the next upload.
    up_samples = '{14'd100, 14'd200, 14'd300, 14'd400};
    run_upload(8'h04, 16'd4, 32'h0010_0000, 4);
    // Same waveform single-pass.
    run_upload(8'h00, 16'd4, 32'h0010_0000, 4);
    // Half-rate loop: each sample held two clocks.
    up_samples = '{14'd5, 14'd9};
    run_upload(8'h04, 16'd2, 32'h0008_0000, 2);

    // Partial upload: full-scale sample, stale tail, and an out-of-range byte pair that
    // would alias to address 0 if the sample index were truncated.
    up_samples = '{14'h3FFF, 14'd77};
    start_upload();
    send_payload(8'hFB, 16'd4, 32'h0010_0000, 2);
    send_byte(16'd8199, 8'h55);
    send_byte(16'd8200, 8'h2A);
    finish_cmd(p, l);
    drain(1'b1);

    run_upload(8'h04, 16'd0, 32'h0010_0000, 0);
    run_upload(8'h04, 16'd4, 32'h0000_0000, 0);
    run_upload(8'h04, 16'd4097, 32'h0010_0000, 0);

    // Oversized rate word gets clamped.
    up_samples = '{14'd11, 14'd22, 14'd33};
    run_upload(8'h04, 16'd3, 32'hFFFF_FFFF, 3);

    for (int it = 0; it < 8; it++) begin
      rn = 16'($urandom_range(1, 8));
      rr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF
                                       : 32'($urandom_range(32'h0002_0000, 32'h0030_0000));
      rc = 8'($urandom);
      up_samples.delete();
      for (int k = 0; k < int'(rn); k++) up_samples.push_back(14'($urandom));
      run_upload(rc, rn, rr, int'(rn));
    end

    // Reset during playback.
    up_samples = '{14'd100, 14'd200, 14'd300, 14'd400};
    start_upload();
    send_payload(8'h04, 16'd4, 32'h0010_0000, 4);
    finish_cmd(p, l);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    check("rst_play_playing", 32'(playing), 32'd0);
    check("rst_play_dac", 32'(dac_data), 32'd0);
    check("rst_play_ready", 32'(cmd_ready), 32'd0);
    exp_q.delete();
    rst = 1'b0;
    #1;
    check("ready_after_rst2", 32'(cmd_ready), 32'd1);

    // Reset during receive: the high byte presented with reset must not reach RAM.
    start_upload();
    send_payload(8'h04, 16'd1, 32'h0010_0000, 0);
    send_byte(16'd7, 8'h34);
    rst = 1'b1;
    cmd_data_valid = 1'b1;
    cmd_data_index = 16'd8;
    cmd_data       = 8'h12;
    tick();
    cmd_data_valid = 1'b0;
    check("rst_recv_playing", 32'(playing), 32'd0);
    rst = 1'b0;
    run_upload(8'h04, 16'd1, 32'h0010_0000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
